reg_bus_arbiter: RTL

Two-requester arbiter and sequencer for the 8-bit memory-mapped configuration register bus (select/write/addr/wdata/rdata). It sits between two independent bus masters (the config sequencer and the debug/host port) and the `sample_reg_design` register block. It grants one master at a time with round-robin fairness, drives one single-cycle bus access, captures read data, and returns a one-cycle acknowledge to the granted master.

---
 rtl/reg_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin two-master arbiter for the 8-bit config reg bus.
// Optional address legality check: define REG_BUS_ARB_ADDR_CHECK_EN.
module reg_bus_arbiter #(
  parameter int          NUM_REGS    = 10,
  parameter int          ADDR_STRIDE = 8,
  parameter logic [7:0]  RO_BASE     = 8'h40
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  output logic       m0_err,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       m1_err,
  output logic       select,
  output logic       write,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

`ifdef REG_BUS_ARB_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [7:0] STRIDE8 = 8'(ADDR_STRIDE);
  localparam logic [7:0] LAST_A  = 8'((NUM_REGS - 1) * ADDR_STRIDE);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic       last_grant;
  logic       gnt_id;
  logic       stale_vld;
  logic       stale_id;

  logic       req0_v;
  logic       req1_v;
  logic       any_req;
  logic       win;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;
  logic       bad;

  // Arbitration: mask the master just acked, then round-robin on contention.
  always_comb begin
    req0_v  = m0_req && !(stale_vld && !stale_id);
    req1_v  = m1_req && !(stale_vld && stale_id);
    any_req = req0_v || req1_v;
    if (req0_v && req1_v) begin
      win = ~last_grant;
    end else begin
      win = req1_v;
    end
    w_we    = win ? m1_we    : m0_we;
    w_addr  = win ? m1_addr  : m0_addr;
    w_wdata = win ? m1_wdata : m0_wdata;
    bad = CHK_EN &&
          (((w_addr % STRIDE8) != 8'd0) ||
           (w_addr > LAST_A) ||
           (w_we && (w_addr >= RO_BASE)));
  end

  // Transaction sequencer with registered bus and master outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      stale_vld  <= 1'b0;
      stale_id   <= 1'b0;
      select     <= 1'b0;
      write      <= 1'b0;
      addr       <= 8'h00;
      wdata      <= 8'h00;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= 8'h00;
      m1_rdata   <= 8'h00;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          stale_vld <= 1'b0;
          if (any_req) begin
            gnt_id     <= win;
            last_grant <= win;
            addr       <= w_addr;
            wdata      <= w_wdata;
            if (bad) begin
              state <= RESP;
              if (win) begin
                m1_ack <= 1'b1;
                m1_err <= 1'b1;
              end else begin
                m0_ack <= 1'b1;
                m0_err <= 1'b1;
              end
            end else begin
              state  <= ACCESS;
              select <= 1'b1;
              write  <= w_we;
            end
          end
        end
        ACCESS: begin
          state  <= RESP;
          select <= 1'b0;
          write  <= 1'b0;
          if (gnt_id) begin
            m1_ack <= 1'b1;
            if (!write) m1_rdata <= rdata;
          end else begin
            m0_ack <= 1'b1;
            if (!write) m0_rdata <= rdata;
          end
        end
        RESP: begin
          state     <= IDLE;
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
          stale_vld <= 1'b1;
          stale_id  <= gnt_id;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
